// File: rtl/sequenciador_giro_lateral_pkg.sv
// Shared definitions for the lateral servo sequencer: FSM state codes and default interval lengths.
package giro_pkg;

   localparam int T_QUARTO_PADRAO = 25000000;
   localparam int T_PAUSA_PADRAO  = 5000000;

   typedef enum logic [2:0] {
      INICIAL = 3'd0,
      GIRA    = 3'd1,
      PAUSA   = 3'd2,
      FIM     = 3'd3
   } estado_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sequenciador_giro_lateral_if.sv
// Command/status bundle between the cube-solving FSM (master) and the lateral sequencer (slave).
// With GIRO_ABORT_EN defined the bundle also carries parar/abortado.
interface sequenciador_giro_lateral_if;
   logic       iniciar;
   logic [1:0] n_quartos;
   logic       girar;
   logic       ocupado;
   logic       pronto;
   logic [2:0] db_estado;
`ifdef GIRO_ABORT_EN
   logic       parar;
   logic       abortado;

   modport master (output iniciar, n_quartos, parar,
                   input  girar, ocupado, pronto, db_estado, abortado);
   modport slave  (input  iniciar, n_quartos, parar,
                   output girar, ocupado, pronto, db_estado, abortado);
`else
   modport master (output iniciar, n_quartos,
                   input  girar, ocupado, pronto, db_estado);
   modport slave  (input  iniciar, n_quartos,
                   output girar, ocupado, pronto, db_estado);
`endif
endinterface

// File: rtl/sequenciador_giro_lateral_contador.sv
// Interval timer shared by the rotate and pause phases; terminal flags the last cycle of the interval.
module contador_giro #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] modulo,
   output logic         terminal
);

   logic [W-1:0] valor_q, valor_d;

   always_comb begin
      valor_d = valor_q;
      if (clr)     valor_d = '0;
      else if (en) valor_d = valor_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) valor_q <= '0;
      else        valor_q <= valor_d;
   end

   assign terminal = en && (valor_q == modulo - 1'b1);

endmodule

// File: rtl/sequenciador_giro_lateral.sv
// Turns a "rotate N quarter turns" command into an open-loop timed girar level for the lateral servo.
// Optional GIRO_ABORT_EN adds parar (abort to FIM) and abortado (flags the aborted FIM cycle).
module sequenciador_giro_lateral
   import giro_pkg::*;
#(
   parameter int T_QUARTO = T_QUARTO_PADRAO,
   parameter int T_PAUSA  = T_PAUSA_PADRAO
) (
   input  logic                          clock,
   input  logic                          reset,
   sequenciador_giro_lateral_if.slave    bus
);

   localparam int W = $clog2(max_int(T_QUARTO, T_PAUSA) + 1);
   localparam logic [W-1:0] MOD_QUARTO = W'(T_QUARTO);
   localparam logic [W-1:0] MOD_PAUSA  = W'(T_PAUSA);

   estado_t    estado_q, estado_d;
   logic [1:0] restantes_q, restantes_d;
   logic       girar_q, girar_d;
   logic       ocupado_q, ocupado_d;
   logic       pronto_q, pronto_d;
   logic       cont_clr, cont_en, cont_fim;
   logic [W-1:0] cont_mod;
`ifdef GIRO_ABORT_EN
   logic       abortado_q, abortado_d;
`endif

   assign cont_en  = (estado_q == GIRA) || (estado_q == PAUSA);
   assign cont_mod = (estado_q == GIRA) ? MOD_QUARTO : MOD_PAUSA;

   contador_giro #(.W(W)) u_contador (
      .clk      (clock),
      .rst_n    (reset),
      .clr      (cont_clr),
      .en       (cont_en),
      .modulo   (cont_mod),
      .terminal (cont_fim)
   );

   always_comb begin
      estado_d    = estado_q;
      restantes_d = restantes_q;
      cont_clr    = 1'b1;
`ifdef GIRO_ABORT_EN
      abortado_d  = 1'b0;
`endif
      case (estado_q)
         INICIAL: begin
            if (bus.iniciar) begin
               if (bus.n_quartos != 2'd0) begin
                  restantes_d = bus.n_quartos;
                  estado_d    = GIRA;
               end else begin
                  estado_d    = FIM;
               end
            end
         end
         GIRA: begin
            cont_clr = 1'b0;
            if (cont_fim) begin
               cont_clr    = 1'b1;
               restantes_d = restantes_q - 2'd1;
               estado_d    = (restantes_q > 2'd1) ? PAUSA : FIM;
            end
         end
         PAUSA: begin
            cont_clr = 1'b0;
            if (cont_fim) begin
               cont_clr = 1'b1;
               estado_d = GIRA;
            end
         end
         FIM:     estado_d = INICIAL;
         default: estado_d = INICIAL;
      endcase
`ifdef GIRO_ABORT_EN
      // Abort overrides a same-cycle interval expiry.
      if (bus.parar && cont_en) begin
         estado_d    = FIM;
         restantes_d = 2'd0;
         cont_clr    = 1'b1;
         abortado_d  = 1'b1;
      end
`endif
      // Outputs are decoded from the next state so they register alongside it.
      girar_d   = (estado_d == GIRA);
      ocupado_d = (estado_d != INICIAL);
      pronto_d  = (estado_d == FIM);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q    <= INICIAL;
         restantes_q <= 2'd0;
         girar_q     <= 1'b0;
         ocupado_q   <= 1'b0;
         pronto_q    <= 1'b0;
`ifdef GIRO_ABORT_EN
         abortado_q  <= 1'b0;
`endif
      end else begin
         estado_q    <= estado_d;
         restantes_q <= restantes_d;
         girar_q     <= girar_d;
         ocupado_q   <= ocupado_d;
         pronto_q    <= pronto_d;
`ifdef GIRO_ABORT_EN
         abortado_q  <= abortado_d;
`endif
      end
   end

   assign bus.girar     = girar_q;
   assign bus.ocupado   = ocupado_q;
   assign bus.pronto    = pronto_q;
   assign bus.db_estado = estado_q;
`ifdef GIRO_ABORT_EN
   assign bus.abortado  = abortado_q;
`endif

endmodule

// File: tb/tb_sequenciador_giro_lateral.sv
// Bench for the lateral sequencer: per-cycle output traces compared against a trace model built from the timing rules.
module tb_sequenciador_giro_lateral;

   localparam int TQ = 10;
   localparam int TP = 4;

   // Trace entry: {girar, ocupado, pronto, db_estado[2:0]}
   localparam logic [5:0] E_GIRA  = 6'b110_001;
   localparam logic [5:0] E_PAUSA = 6'b010_010;
   localparam logic [5:0] E_FIM   = 6'b011_011;
   localparam logic [5:0] E_OCIO  = 6'b000_000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [5:0] esperado[$];

   sequenciador_giro_lateral_if bus();

   sequenciador_giro_lateral #(.T_QUARTO(TQ), .T_PAUSA(TP)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] obs();
      return {bus.girar, bus.ocupado, bus.pronto, bus.db_estado};
   endfunction

   // Expected trace from the cycle after acceptance until the block is idle again.
   task automatic modelo(input int n);
      esperado.delete();
      for (int q = 1; q <= n; q++) begin
         repeat (TQ) esperado.push_back(E_GIRA);
         if (q < n) repeat (TP) esperado.push_back(E_PAUSA);
      end
      esperado.push_back(E_FIM);
      esperado.push_back(E_OCIO);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.iniciar = 1'b1;
      bus.n_quartos = 2'd1;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (obs() !== E_OCIO) begin
            failures++;
            $display("FAIL reset_hold obs=%b exp=%b", obs(), E_OCIO);
         end
      end
      bus.iniciar = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (obs() !== E_OCIO) begin
         failures++;
         $display("FAIL reset_release obs=%b exp=%b", obs(), E_OCIO);
      end
   endtask

   task automatic test_um_quarto();
      int n_girar = 0;
      int n_ocup = 0;
      bus.iniciar = 1'b1;
      bus.n_quartos = 2'd1;
      modelo(1);
      foreach (esperado[i]) begin
         @(negedge clk);
         bus.iniciar = 1'b0;
         n_girar += int'(bus.girar);
         n_ocup  += int'(bus.ocupado);
         checks++;
         if (obs() !== esperado[i]) begin
            failures++;
            $display("FAIL um_quarto[%0d] obs=%b exp=%b", i, obs(), esperado[i]);
         end
      end
      checks++;
      if (n_girar != TQ || n_ocup != TQ + 1) begin
         failures++;
         $display("FAIL um_quarto_contagem girar=%0d ocupado=%0d exp=%0d/%0d", n_girar, n_ocup, TQ, TQ + 1);
      end
   endtask

   task automatic test_tres_quartos();
      int n_ocup = 0;
      bus.iniciar = 1'b1;
      bus.n_quartos = 2'd3;
      modelo(3);
      foreach (esperado[i]) begin
         @(negedge clk);
         bus.iniciar = 1'b0;
         n_ocup += int'(bus.ocupado);
         checks++;
         if (obs() !== esperado[i]) begin
            failures++;
            $display("FAIL tres_quartos[%0d] obs=%b exp=%b", i, obs(), esperado[i]);
         end
      end
      checks++;
      if (n_ocup != 3 * TQ + 2 * TP + 1) begin
         failures++;
         $display("FAIL tres_quartos_ocupado obs=%0d exp=%0d", n_ocup, 3 * TQ + 2 * TP + 1);
      end
   endtask

   task automatic test_zero_quartos();
      bus.iniciar = 1'b1;
      bus.n_quartos = 2'd0;
      modelo(0);
      foreach (esperado[i]) begin
         @(negedge clk);
         bus.iniciar = 1'b0;
         checks++;
         if (obs() !== esperado[i]) begin
            failures++;
            $display("FAIL zero_quartos[%0d] obs=%b exp=%b", i, obs(), esperado[i]);
         end
      end
   endtask

   task automatic test_ignora_iniciar();
      bus.iniciar = 1'b1;
      bus.n_quartos = 2'd2;
      modelo(2);
      foreach (esperado[i]) begin
         @(negedge clk);
         bus.iniciar = 1'b0;
         // Re-pulse mid-GIRA with a different count, and again while in FIM.
         if (i == 3) begin bus.iniciar = 1'b1; bus.n_quartos = 2'd3; end
         if (i == esperado.size() - 2) bus.iniciar = 1'b1;
         checks++;
         if (obs() !== esperado[i]) begin
            failures++;
            $display("FAIL ignora_iniciar[%0d] obs=%b exp=%b", i, obs(), esperado[i]);
         end
      end
      @(negedge clk);
      checks++;
      if (obs() !== E_OCIO) begin
         failures++;
         $display("FAIL ignora_iniciar_ocio obs=%b exp=%b", obs(), E_OCIO);
      end
   endtask

   task automatic test_reset_meio();
      bus.iniciar = 1'b1;
      bus.n_quartos = 2'd2;
      modelo(2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.iniciar = 1'b0;
         checks++;
         if (obs() !== esperado[i]) begin
            failures++;
            $display("FAIL reset_meio_gira[%0d] obs=%b exp=%b", i, obs(), esperado[i]);
         end
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (obs() !== E_OCIO) begin
         failures++;
         $display("FAIL reset_meio_parada obs=%b exp=%b", obs(), E_OCIO);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (obs() !== E_OCIO) begin
            failures++;
            $display("FAIL reset_meio_sem_pronto obs=%b exp=%b", obs(), E_OCIO);
         end
      end
      // A fresh command must see a cleared timer.
      bus.iniciar = 1'b1;
      bus.n_quartos = 2'd1;
      modelo(1);
      foreach (esperado[i]) begin
         @(negedge clk);
         bus.iniciar = 1'b0;
         checks++;
         if (obs() !== esperado[i]) begin
            failures++;
            $display("FAIL reset_meio_retoma[%0d] obs=%b exp=%b", i, obs(), esperado[i]);
         end
      end
   endtask

   task automatic test_aleatorio();
      for (int it = 0; it < 25; it++) begin
         int n;
         n = int'($urandom_range(0, 3));
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            checks++;
            if (obs() !== E_OCIO) begin
               failures++;
               $display("FAIL aleatorio_ocio it=%0d obs=%b exp=%b", it, obs(), E_OCIO);
            end
         end
         bus.iniciar = 1'b1;
         bus.n_quartos = 2'(n);
         modelo(n);
         foreach (esperado[i]) begin
            @(negedge clk);
            // Noise on the command inputs while busy must change nothing.
            bus.iniciar = (i < esperado.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.n_quartos = 2'($urandom_range(0, 3));
            checks++;
            if (obs() !== esperado[i]) begin
               failures++;
               $display("FAIL aleatorio it=%0d n=%0d [%0d] obs=%b exp=%b", it, n, i, obs(), esperado[i]);
            end
         end
      end
   endtask

`ifdef GIRO_ABORT_EN
   task automatic test_aborto();
      bus.parar = 1'b1;
      @(negedge clk);
      bus.parar = 1'b0;
      checks++;
      if (obs() !== E_OCIO || bus.abortado !== 1'b0) begin
         failures++;
         $display("FAIL aborto_inicial obs=%b abortado=%b exp=%b/0", obs(), bus.abortado, E_OCIO);
      end
      bus.iniciar = 1'b1;
      bus.n_quartos = 2'd3;
      modelo(3);
      // Index TQ+2 is the third cycle of the first pause.
      for (int i = 0; i <= TQ + 2; i++) begin
         @(negedge clk);
         bus.iniciar = 1'b0;
         checks++;
         if (obs() !== esperado[i] || bus.abortado !== 1'b0) begin
            failures++;
            $display("FAIL aborto_antes[%0d] obs=%b abortado=%b exp=%b/0", i, obs(), bus.abortado, esperado[i]);
         end
      end
      bus.parar = 1'b1;
      @(negedge clk);
      bus.parar = 1'b0;
      checks++;
      if (obs() !== E_FIM || bus.abortado !== 1'b1) begin
         failures++;
         $display("FAIL aborto_fim obs=%b abortado=%b exp=%b/1", obs(), bus.abortado, E_FIM);
      end
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (obs() !== E_OCIO || bus.abortado !== 1'b0) begin
            failures++;
            $display("FAIL aborto_depois obs=%b abortado=%b exp=%b/0", obs(), bus.abortado, E_OCIO);
         end
      end
   endtask
`endif

   initial begin
      bus.iniciar = 1'b0;
      bus.n_quartos = 2'd0;
`ifdef GIRO_ABORT_EN
      bus.parar = 1'b0;
`endif
      test_reset();
      test_um_quarto();
      test_tres_quartos();
      test_zero_quartos();
      test_ignora_iniciar();
      test_reset_meio();
      test_aleatorio();
`ifdef GIRO_ABORT_EN
      test_aborto();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
